// File: rtl/fp_mult_sequencer_pkg.sv
// Shared definitions for the FP multiplier sequencer: state encoding,
// result flag bit positions and default sizing.
package fp_mult_sequencer_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 4;

   localparam int FLAG_W   = 3;
   localparam int FLAG_NAN = 2;
   localparam int FLAG_INF = 1;
   localparam int FLAG_OVF = 0;

   typedef enum logic [2:0] {
      ST_CLEAR   = 3'd0,
      ST_IDLE    = 3'd1,
      ST_LOAD    = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_COLLECT = 3'd4
   } state_t;

   typedef struct packed {
      logic we_a;
      logic we_b;
      logic re_a;
      logic re_b;
      logic we_out;
      logic re_out;
      logic rst_a;
      logic rst_b;
      logic rst_out;
   } dp_ctrl_t;

endpackage

// File: rtl/fp_mult_sequencer_result_fifo.sv
// Count-based result FIFO holding {flags, product} entries; DEPTH must be a
// power of two so the pointers wrap naturally.
module result_fifo #(
   parameter int WIDTH = 35,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             valid,
   output logic             full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign valid     = (count != '0);
   assign full      = (count == FULL_COUNT);
   assign do_push   = push && !full;
   assign do_pop    = pop && valid;
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: nothing is visible until count is non-zero.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fp_mult_sequencer.sv
// Sequences operand pairs through an external registered FP multiplier and
// queues the products with their NAN/infinity/overflow flags.
//
// state   | meaning
// CLEAR   | pulse datapath register resets for one cycle
// IDLE    | accept an operand pair when the FIFO has room
// LOAD    | write operands into datapath input registers
// CAPTURE | write product register, sample datapath flags
// COLLECT | read product register, push {flags, product}
module fp_mult_sequencer
   import fp_mult_sequencer_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              inValid,
   output logic              inReady,
   input  logic [WIDTH-1:0]  inA,
   input  logic [WIDTH-1:0]  inB,
   output logic              outValid,
   input  logic              outReady,
   output logic [WIDTH-1:0]  outProduct,
   output logic [FLAG_W-1:0] outFlags,
   output logic [WIDTH-1:0]  dpA,
   output logic [WIDTH-1:0]  dpB,
   output logic              dpWriteEnableA,
   output logic              dpWriteEnableB,
   output logic              dpReadEnableA,
   output logic              dpReadEnableB,
   output logic              dpWriteEnableOut,
   output logic              dpReadEnableOut,
   output logic              dpResetA,
   output logic              dpResetB,
   output logic              dpResetOut,
   input  logic [WIDTH-1:0]  dpProduct,
   input  logic              dpOverflow,
   input  logic              dpInfinity,
   input  logic              dpNAN,
   output logic              busy
);

   state_t                    state;
   state_t                    next_state;
   dp_ctrl_t                  ctrl;
   logic [WIDTH-1:0]          op_a;
   logic [WIDTH-1:0]          op_b;
   logic [FLAG_W-1:0]         flag_reg;
   logic [FLAG_W-1:0]         flags_now;
   logic                      take;
   logic                      fifo_push;
   logic                      fifo_valid;
   logic                      fifo_full;
   logic [WIDTH+FLAG_W-1:0]   fifo_head;

   assign take = inValid && inReady;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state <= ST_CLEAR;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         ST_CLEAR:   next_state = ST_IDLE;
         ST_IDLE:    if (take) next_state = ST_LOAD;
         ST_LOAD:    next_state = ST_CAPTURE;
         ST_CAPTURE: next_state = ST_COLLECT;
         ST_COLLECT: next_state = ST_IDLE;
         default:    next_state = ST_CLEAR;
      endcase
   end

   always_comb begin
      ctrl    = '0;
      inReady = 1'b0;
      unique case (state)
         ST_CLEAR: begin
            ctrl.rst_a   = 1'b1;
            ctrl.rst_b   = 1'b1;
            ctrl.rst_out = 1'b1;
         end
         ST_IDLE: inReady = !fifo_full;
         ST_LOAD: begin
            ctrl.we_a = 1'b1;
            ctrl.we_b = 1'b1;
            ctrl.re_a = 1'b1;
            ctrl.re_b = 1'b1;
         end
         ST_CAPTURE: begin
            ctrl.re_a   = 1'b1;
            ctrl.re_b   = 1'b1;
            ctrl.we_out = 1'b1;
         end
         ST_COLLECT: ctrl.re_out = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      flags_now           = '0;
      flags_now[FLAG_NAN] = dpNAN;
      flags_now[FLAG_INF] = dpInfinity;
      flags_now[FLAG_OVF] = dpOverflow;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         op_a     <= '0;
         op_b     <= '0;
         flag_reg <= '0;
      end else begin
         if (take) begin
            op_a <= inA;
            op_b <= inB;
         end
         if (state == ST_CAPTURE) flag_reg <= flags_now;
      end
   end

   // The slot is reserved at acceptance (inReady checks full), so a push in
   // COLLECT always finds room.
   assign fifo_push = (state == ST_COLLECT);

   result_fifo #(
      .WIDTH (WIDTH + FLAG_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (resetN),
      .push      (fifo_push),
      .push_data ({flag_reg, dpProduct}),
      .pop       (outReady),
      .head_data (fifo_head),
      .valid     (fifo_valid),
      .full      (fifo_full)
   );

   assign outValid         = fifo_valid;
   assign outProduct       = fifo_head[WIDTH-1:0];
   assign outFlags         = fifo_head[WIDTH+FLAG_W-1:WIDTH];
   assign dpA              = op_a;
   assign dpB              = op_b;
   assign dpWriteEnableA   = ctrl.we_a;
   assign dpWriteEnableB   = ctrl.we_b;
   assign dpReadEnableA    = ctrl.re_a;
   assign dpReadEnableB    = ctrl.re_b;
   assign dpWriteEnableOut = ctrl.we_out;
   assign dpReadEnableOut  = ctrl.re_out;
   assign dpResetA         = ctrl.rst_a;
   assign dpResetB         = ctrl.rst_b;
   assign dpResetOut       = ctrl.rst_out;
   assign busy             = (state != ST_IDLE) || fifo_valid;

endmodule

// File: tb/tb_fp_mult_sequencer.sv
// Bench for fp_mult_sequencer: registered FP multiplier datapath model,
// queue scoreboard with a negedge monitor, directed and random pairs.
module tb_fp_mult_sequencer;

   logic        clk = 1'b0;
   logic        resetN;
   logic        inValid;
   logic        inReady;
   logic [31:0] inA;
   logic [31:0] inB;
   logic        outValid;
   logic        outReady;
   logic [31:0] outProduct;
   logic [2:0]  outFlags;
   logic [31:0] dpA;
   logic [31:0] dpB;
   logic        dpWriteEnableA;
   logic        dpWriteEnableB;
   logic        dpReadEnableA;
   logic        dpReadEnableB;
   logic        dpWriteEnableOut;
   logic        dpReadEnableOut;
   logic        dpResetA;
   logic        dpResetB;
   logic        dpResetOut;
   logic [31:0] dpProduct;
   logic        dpOverflow;
   logic        dpInfinity;
   logic        dpNAN;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int xfer_cycle = 0;
   logic [34:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fp_mult_sequencer dut (
      .clk              (clk),
      .resetN           (resetN),
      .inValid          (inValid),
      .inReady          (inReady),
      .inA              (inA),
      .inB              (inB),
      .outValid         (outValid),
      .outReady         (outReady),
      .outProduct       (outProduct),
      .outFlags         (outFlags),
      .dpA              (dpA),
      .dpB              (dpB),
      .dpWriteEnableA   (dpWriteEnableA),
      .dpWriteEnableB   (dpWriteEnableB),
      .dpReadEnableA    (dpReadEnableA),
      .dpReadEnableB    (dpReadEnableB),
      .dpWriteEnableOut (dpWriteEnableOut),
      .dpReadEnableOut  (dpReadEnableOut),
      .dpResetA         (dpResetA),
      .dpResetB         (dpResetB),
      .dpResetOut       (dpResetOut),
      .dpProduct        (dpProduct),
      .dpOverflow       (dpOverflow),
      .dpInfinity       (dpInfinity),
      .dpNAN            (dpNAN),
      .busy             (busy)
   );

   // Single-precision multiply, truncating, subnormals flushed to zero.
   // Returns {nan, infinity, overflow, product}.
   function automatic logic [34:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic        s;
      logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      logic [47:0] m;
      logic [22:0] frac;
      int          e;
      s      = a[31] ^ b[31];
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
      a_zero = (a[30:23] == 8'h00);
      b_zero = (b[30:23] == 8'h00);
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
         return {3'b100, 32'h7FC00000};
      if (a_inf || b_inf) return {3'b010, s, 8'hFF, 23'd0};
      if (a_zero || b_zero) return {3'b000, s, 31'd0};
      m = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (m[47]) begin
         e    = e + 1;
         frac = m[46:24];
      end else begin
         frac = m[45:23];
      end
      if (e >= 255) return {3'b011, s, 8'hFF, 23'd0};
      if (e <= 0)   return {3'b000, s, 31'd0};
      return {3'b000, s, e[7:0], frac};
   endfunction

   // Registered multiplier datapath: input regs, combinational flags, product reg.
   logic [31:0] reg_a = '0;
   logic [31:0] reg_b = '0;
   logic [31:0] reg_p = '0;
   logic [34:0] comb_res;
   assign comb_res = fp_mul(reg_a, reg_b);
   always @(posedge clk) begin
      if (dpResetA) reg_a <= '0; else if (dpWriteEnableA) reg_a <= dpA;
      if (dpResetB) reg_b <= '0; else if (dpWriteEnableB) reg_b <= dpB;
      if (dpResetOut) reg_p <= '0; else if (dpWriteEnableOut) reg_p <= comb_res[31:0];
   end
   assign dpProduct  = dpReadEnableOut ? reg_p : 32'd0;
   assign dpNAN      = dpReadEnableA && dpReadEnableB && comb_res[34];
   assign dpInfinity = dpReadEnableA && dpReadEnableB && comb_res[33];
   assign dpOverflow = dpReadEnableA && dpReadEnableB && comb_res[32];

   wire [5:0] en   = {dpWriteEnableA, dpWriteEnableB, dpReadEnableA, dpReadEnableB,
                      dpWriteEnableOut, dpReadEnableOut};
   wire [2:0] rsts = {dpResetA, dpResetB, dpResetOut};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: pops an expectation for every accepted result.
   initial begin
      logic        stall_prev;
      logic [34:0] stall_val;
      logic [34:0] e;
      stall_prev = 1'b0;
      stall_val  = '0;
      forever begin
         @(negedge clk);
         if (!resetN) begin
            stall_prev = 1'b0;
         end else begin
            if (outValid && !outReady) begin
               if (stall_prev) check("stall_stable", 64'({outFlags, outProduct}), 64'(stall_val));
               stall_prev = 1'b1;
               stall_val  = {outFlags, outProduct};
            end else begin
               stall_prev = 1'b0;
            end
            if (outValid && outReady) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_result: got %h want none", {outFlags, outProduct});
               end else begin
                  e = exp_q.pop_front();
                  check("result", 64'({outFlags, outProduct}), 64'(e));
               end
            end
         end
      end
   end

   // Offer a pair for up to budget cycles; queue its expectation on acceptance.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [34:0] e,
                       input int budget, output bit ok);
      inValid = 1'b1;
      inA     = a;
      inB     = b;
      ok      = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (inReady) begin
            exp_q.push_back(e);
            xfer_cycle = cyc;
            ok = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      inValid = 1'b0;
      inA     = $urandom;
      inB     = $urandom;
   endtask

   task automatic send_chk(input logic [31:0] a, input logic [31:0] b, input logic [34:0] e);
      bit ok;
      send(a, b, e, 40, ok);
      check("accept", 64'(ok), 64'd1);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 300 && (exp_q.size() != 0 || busy); i++) begin
         @(posedge clk);
         #1;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   function automatic logic [31:0] rand_fp();
      int sel;
      sel = $urandom_range(0, 15);
      case (sel)
         0:       return {1'($urandom), 8'hFF, 23'($urandom_range(1, 8388607))};
         1:       return {1'($urandom), 8'hFF, 23'd0};
         2:       return {1'($urandom), 31'd0};
         3:       return {1'($urandom), 8'($urandom_range(200, 254)), 23'($urandom)};
         default: return {1'($urandom), 8'($urandom_range(90, 164)), 23'($urandom)};
      endcase
   endfunction

   initial begin
      bit          ok;
      bit          done;
      int          accepted;
      int          t1;
      logic [31:0] a;
      logic [31:0] b;
      resetN   = 1'b0;
      inValid  = 1'b0;
      inA      = '0;
      inB      = '0;
      outReady = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(outValid), 64'd0);
      check("rst_in_ready", 64'(inReady), 64'd0);
      check("rst_busy", 64'(busy), 64'd1);
      check("rst_enables", 64'(en), 64'd0);
      check("rst_dp_ops", 64'({dpA, dpB}), 64'd0);
      @(posedge clk);
      #1 resetN = 1'b1;
      @(negedge clk);
      check("clear_resets", 64'(rsts), 64'h7);
      check("clear_in_ready", 64'(inReady), 64'd0);
      @(posedge clk);
      @(negedge clk);
      check("idle_resets", 64'(rsts), 64'd0);
      check("idle_in_ready", 64'(inReady), 64'd1);
      check("idle_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;

      // 2.0 x 3.0 with per-state enable trace and latency
      outReady = 1'b1;
      send_chk(32'h40000000, 32'h40400000, {3'b000, 32'h40C00000});
      @(negedge clk);
      check("load_enables", 64'(en), 64'h3C);
      check("load_ops", 64'({dpA, dpB}), {32'h40000000, 32'h40400000});
      @(posedge clk);
      @(negedge clk);
      check("capture_enables", 64'(en), 64'h0E);
      @(posedge clk);
      @(negedge clk);
      check("collect_enables", 64'(en), 64'h01);
      check("collect_out_valid", 64'(outValid), 64'd0);
      @(posedge clk);
      @(negedge clk);
      check("latency_out_valid", 64'(outValid), 64'd1);
      check("idle_enables", 64'(en), 64'd0);
      @(posedge clk);
      #1;

      send_chk(32'h7FC00000, 32'h3F800000, {3'b100, 32'h7FC00000});
      send_chk(32'h7F000000, 32'h7F000000, {3'b011, 32'h7F800000});
      send_chk(32'hC0000000, 32'h3FC00000, {3'b000, 32'hC0400000});
      t1 = xfer_cycle;
      send_chk(32'h3F800000, 32'h00000000, {3'b000, 32'h00000000});
      check("throughput", 64'(xfer_cycle - t1), 64'd4);
      wait_drain();

      // FIFO full: six offered, four accepted
      outReady = 1'b0;
      accepted = 0;
      for (int i = 0; i < 6; i++) begin
         a = rand_fp();
         b = rand_fp();
         send(a, b, fp_mul(a, b), 12, ok);
         accepted += int'(ok);
      end
      check("full_accepted", 64'(accepted), 64'd4);
      @(negedge clk);
      check("full_in_ready", 64'(inReady), 64'd0);
      check("full_busy", 64'(busy), 64'd1);
      @(posedge clk);
      #1 outReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("after_pop_in_ready", 64'(inReady), 64'd1);
      @(posedge clk);
      #1;
      wait_drain();

      // Push and pop on the same edge with two entries queued
      outReady = 1'b0;
      send_chk(32'h40800000, 32'h40800000, {3'b000, 32'h41800000});
      send_chk(32'h3F000000, 32'h40000000, {3'b000, 32'h3F800000});
      send_chk(32'h41200000, 32'h41200000, {3'b000, 32'h42C80000});
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 outReady = 1'b1;
      @(posedge clk);
      #1 outReady = 1'b0;
      @(negedge clk);
      check("simul_count", 64'(dut.u_fifo.count), 64'd2);
      check("simul_queue", 64'(exp_q.size()), 64'd2);
      @(posedge clk);
      #1 outReady = 1'b1;
      wait_drain();

      // Reset during CAPTURE discards in-flight and queued results
      outReady = 1'b0;
      send_chk(32'h40000000, 32'h40000000, {3'b000, 32'h40800000});
      send_chk(32'h40400000, 32'h40400000, {3'b000, 32'h41100000});
      @(posedge clk);
      #1 resetN = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("midrst_out_valid", 64'(outValid), 64'd0);
      check("midrst_busy", 64'(busy), 64'd1);
      check("midrst_enables", 64'(en), 64'd0);
      check("midrst_ops", 64'({dpA, dpB}), 64'd0);
      @(posedge clk);
      #1 resetN = 1'b1;
      @(negedge clk);
      check("midrst_clear_resets", 64'(rsts), 64'h7);
      check("midrst_clear_ready", 64'(inReady), 64'd0);
      check("midrst_fifo_empty", 64'(outValid), 64'd0);
      @(posedge clk);
      #1 outReady = 1'b1;
      send_chk(32'h40A00000, 32'h40000000, {3'b000, 32'h41200000});
      wait_drain();

      // Random pairs with random back-pressure
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 24; i++) begin
               a = rand_fp();
               b = rand_fp();
               send_chk(a, b, fp_mul(a, b));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1 outReady = 1'($urandom_range(0, 1));
            end
         end
      join
      outReady = 1'b1;
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
